// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and MEM-stage data access
// onto one single-port memory with a fixed access latency.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request and address
//   if_rdata/if_valid           fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request (load or store)
//   d_rdata/d_valid             load data, one-cycle completion pulse
//   stall_if/stall_mem          combinational stalls to the hazard unit
//   mem_en/mem_we/mem_addr/     memory macro interface
//   mem_wdata/mem_rdata
//   busy                        arbiter is not idle
module mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LAT  = 2,
    parameter int MAXD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(LAT + 1);
    localparam int SW = (MAXD > 0) ? $clog2(MAXD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;   // 1 = data, 0 = fetch
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic streak_full;
    logic fetch_win;

    assign streak_full = (streak_q == SW'(MAXD));
    // Data has priority until it has starved a pending fetch MAXD times.
    assign fetch_win   = if_req & (~d_req | streak_full);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            streak_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d = S_ACCESS;
                    cnt_d   = CW'(1);
                    if (fetch_win) begin
                        owner_d  = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        streak_d = '0;
                    end else begin
                        owner_d = 1'b1;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        // Only grants that bypass a waiting fetch count.
                        if (!if_req)
                            streak_d = '0;
                        else if (!streak_full)
                            streak_d = streak_q + SW'(1);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == CW'(LAT)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    if (!owner_q)
                        if_rdata_d = mem_rdata;
                    else if (!we_q)
                        d_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_valid  = (state_q == S_RESP) & ~owner_q;
    assign d_valid   = (state_q == S_RESP) & owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter,
// one LAT=2 instance plus LAT=1 and LAT=4 instances for latency sweep.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_valid, d_valid, stall_if, stall_mem;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        a_if_req, a_if_valid, a_stall_if, a_stall_mem;
    logic [31:0] a_if_addr, a_if_rdata, a_d_rdata;
    logic        a_d_valid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_if_req, b_if_valid, b_stall_if, b_stall_mem;
    logic [31:0] b_if_addr, b_if_rdata, b_d_rdata;
    logic        b_d_valid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic        zero_b;
    logic [31:0] zero_w;

    logic [31:0] mem [0:63];

    int checks;
    int errors;

    mem_arbiter #(.AW(32), .DW(32), .LAT(2), .MAXD(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .LAT(1), .MAXD(2)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr),
        .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .d_req(zero_b), .d_we(zero_b), .d_addr(zero_w),
        .d_wdata(zero_w), .d_rdata(a_d_rdata), .d_valid(a_d_valid),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .LAT(4), .MAXD(2)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr),
        .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .d_req(zero_b), .d_we(zero_b), .d_addr(zero_w),
        .d_wdata(zero_w), .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            5:       return 32'hCAFEF00D;
            8:       return 32'h00000013;
            9:       return 32'h00000093;
            default: return 32'h10000000 + i;
        endcase
    endfunction

    // Word-addressed memory; contents reload while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata   = mem[mem_addr[7:2]];
    assign a_mem_rdata = mem[a_mem_addr[7:2]];
    assign b_mem_rdata = mem[b_mem_addr[7:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({busy, if_valid, d_valid, mem_en, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 00000",
                     {busy, if_valid, d_valid, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h exp 0/0",
                     mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h exp 0/0",
                     if_rdata, d_rdata);
        end
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_sweep_busy got %b%b exp 00",
                     a_busy, b_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_load;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL load_mem_en c=%0d got %b", c, mem_en);
            end
            checks++;
            if (d_valid !== (c == 3)) begin
                errors++;
                $display("FAIL load_valid c=%0d got %b", c, d_valid);
            end
            checks++;
            if (stall_mem !== (c <= 2)) begin
                errors++;
                $display("FAIL load_stall c=%0d got %b", c, stall_mem);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 3)) begin
                errors++;
                $display("FAIL load_busy c=%0d got %b", c, busy);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL load_addr got %h/%b exp 10/0",
                             mem_addr, mem_we);
                end
            end
            if (c == 3) begin
                checks++;
                if (d_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL load_rdata got %h exp deadbeef",
                             d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
        end
    endtask

    task automatic test_store_load;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h8;
        d_wdata = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL store_we c=%0d got %b", c, mem_we);
            end
            checks++;
            if (d_valid !== (c == 3)) begin
                errors++;
                $display("FAIL store_valid c=%0d got %b", c, d_valid);
            end
            if (c == 1) begin
                checks++;
                if (mem_wdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL store_wdata got %h exp 12345678",
                             mem_wdata);
                end
            end
            if (c >= 3) begin
                checks++;
                if (d_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL store_rdata_hold got %h exp deadbeef",
                             d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
        end
        d_req = 1'b1;
        d_we  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (d_valid !== (c == 3)) begin
                errors++;
                $display("FAIL reload_valid c=%0d got %b", c, d_valid);
            end
            if (c == 3) begin
                checks++;
                if (d_rdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL reload_rdata got %h exp 12345678",
                             d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous;
        if_req  = 1'b1;
        if_addr = 32'h20;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h14;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (d_valid !== (c == 3) || if_valid !== (c == 7)) begin
                errors++;
                $display("FAIL sim_valid c=%0d got d=%b if=%b",
                         c, d_valid, if_valid);
            end
            checks++;
            if (stall_if !== (c <= 6)) begin
                errors++;
                $display("FAIL sim_stall_if c=%0d got %b", c, stall_if);
            end
            if (c == 3) begin
                checks++;
                if (d_rdata !== 32'hCAFEF00D || if_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL sim_d_rdata got %h/%h exp cafef00d/0",
                             d_rdata, if_rdata);
                end
            end
            if (c == 7) begin
                checks++;
                if (if_rdata !== 32'h13 || d_rdata !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL sim_if_rdata got %h/%h exp 13/cafef00d",
                             if_rdata, d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_starvation;
        int order [6];
        int exp_order [6];
        int n;
        int last_c;
        logic dv, iv;
        exp_order = '{1, 1, 0, 1, 1, 0};
        n = 0;
        last_c = -1;
        if_req  = 1'b1;
        if_addr = 32'h24;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h30;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            dv = d_valid;
            iv = if_valid;
            if (dv) begin
                order[n] = 1;
                n++;
                last_c = c;
            end
            if (iv && n < 6) begin
                order[n] = 0;
                n++;
                last_c = c;
            end
            @(posedge clk);
            #1;
            if (dv) d_addr = d_addr + 32'h4;
            if (n == 6) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL starve_timeout got %0d grants exp 6", n);
            if_req = 1'b0;
            d_req  = 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin
                    errors++;
                    $display("FAIL starve_order k=%0d got %0d exp %0d",
                             k, order[k], exp_order[k]);
                end
            end
            checks++;
            if (last_c != 23) begin
                errors++;
                $display("FAIL starve_last got %0d exp 23", last_c);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid;
        if_req  = 1'b1;
        if_addr = 32'h20;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rmid_access got %b exp 1", mem_en);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (busy !== 1'b0 || mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_idle got busy=%b en=%b exp 0/0",
                             busy, mem_en);
                end
                checks++;
                if (mem_addr !== 32'h0 || if_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL rmid_regs got %h/%h exp 0/0",
                             mem_addr, if_rdata);
                end
            end
            checks++;
            if (if_valid !== (c == 3)) begin
                errors++;
                $display("FAIL rmid_valid c=%0d got %b", c, if_valid);
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 32'h13) begin
                    errors++;
                    $display("FAIL rmid_rdata got %h exp 13", if_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_lat_sweep;
        int na, nb;
        int ta [2];
        int tb [2];
        logic av, bv;
        na = 0;
        nb = 0;
        ta = '{-1, -1};
        tb = '{-1, -1};
        a_if_req  = 1'b1;
        b_if_req  = 1'b1;
        a_if_addr = 32'h20;
        b_if_addr = 32'h20;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            av = a_if_valid;
            bv = b_if_valid;
            if (av && na < 2) begin
                ta[na] = c;
                checks++;
                if (a_if_rdata !== ((na == 0) ? 32'h13 : 32'h93)) begin
                    errors++;
                    $display("FAIL lat1_rdata n=%0d got %h", na, a_if_rdata);
                end
                na++;
            end
            if (bv && nb < 2) begin
                tb[nb] = c;
                checks++;
                if (b_if_rdata !== ((nb == 0) ? 32'h13 : 32'h93)) begin
                    errors++;
                    $display("FAIL lat4_rdata n=%0d got %h", nb, b_if_rdata);
                end
                nb++;
            end
            @(posedge clk);
            #1;
            if (av) begin
                if (na == 1) a_if_addr = 32'h24;
                else a_if_req = 1'b0;
            end
            if (bv) begin
                if (nb == 1) b_if_addr = 32'h24;
                else b_if_req = 1'b0;
            end
        end
        a_if_req = 1'b0;
        b_if_req = 1'b0;
        checks++;
        if (ta[0] != 2 || ta[1] != 5) begin
            errors++;
            $display("FAIL lat1_timing got %0d,%0d exp 2,5", ta[0], ta[1]);
        end
        checks++;
        if (tb[0] != 5 || tb[1] != 11) begin
            errors++;
            $display("FAIL lat4_timing got %0d,%0d exp 5,11", tb[0], tb[1]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        a_if_req  = 1'b0;
        a_if_addr = '0;
        b_if_req  = 1'b0;
        b_if_addr = '0;
        zero_b    = 1'b0;
        zero_w    = '0;
        tick();
        test_reset();
        test_single_load();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_lat_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
